// File: rtl/ysyx_24100012_csr_regfile.sv
// Machine-mode CSR register file: combinational read, edge-committed write,
// ecall/mret trap state and a free-running 64-bit mcycle counter.
module ysyx_24100012_csr_regfile #(
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] MVENDORID  = 32'h7973_7978,
  parameter logic [31:0] MARCHID    = 32'h016F_3A1C
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [11:0]           i_csr_addr,
  input  logic                  i_csr_wen,
  input  logic [DATA_WIDTH-1:0] i_csr_wdata,
  output logic [DATA_WIDTH-1:0] o_csr_rdata,
  output logic                  o_csr_err,
  input  logic                  i_ecall,
  input  logic [DATA_WIDTH-1:0] i_ecall_pc,
  input  logic                  i_mret,
  output logic [DATA_WIDTH-1:0] o_mtvec,
  output logic [DATA_WIDTH-1:0] o_mepc
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MVENDORID = 12'hF11;
  localparam logic [11:0] A_MARCHID   = 12'hF12;

  logic                  r_mie;
  logic                  r_mpie;
  logic [DATA_WIDTH-1:0] r_mtvec;
  logic [DATA_WIDTH-1:0] r_mscratch;
  logic [DATA_WIDTH-1:0] r_mepc;
  logic [DATA_WIDTH-1:0] r_mcause;
  logic [DATA_WIDTH-1:0] r_mcycle;
  logic [DATA_WIDTH-1:0] r_mcycleh;

  logic [DATA_WIDTH-1:0] w_mstatus;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_hit;
  logic                  w_ro;
  logic                  w_wen;
  logic [63:0]           w_cyc_inc;

  // MPP is hardwired to machine mode; only MIE/MPIE are stored
  assign w_mstatus = {19'd0, 2'b11, 3'd0, r_mpie, 3'd0, r_mie, 3'd0};
  assign w_cyc_inc = {r_mcycleh, r_mcycle} + 64'd1;
  assign w_wen     = i_csr_wen & ~i_ecall & ~i_mret;

  always_comb begin
    w_rdata = '0;
    w_hit   = 1'b1;
    w_ro    = 1'b0;
    case (i_csr_addr)
      A_MSTATUS:   w_rdata = w_mstatus;
      A_MTVEC:     w_rdata = r_mtvec;
      A_MSCRATCH:  w_rdata = r_mscratch;
      A_MEPC:      w_rdata = r_mepc;
      A_MCAUSE:    w_rdata = r_mcause;
      A_MCYCLE:    w_rdata = r_mcycle;
      A_MCYCLEH:   w_rdata = r_mcycleh;
      A_MVENDORID: begin w_rdata = MVENDORID; w_ro = 1'b1; end
      A_MARCHID:   begin w_rdata = MARCHID;   w_ro = 1'b1; end
      default:     w_hit = 1'b0;
    endcase
  end

  assign o_csr_rdata = w_rdata;
  assign o_csr_err   = ~w_hit | (w_wen & w_ro);
  assign o_mtvec     = r_mtvec;
  assign o_mepc      = r_mepc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mie      <= 1'b0;
      r_mpie     <= 1'b0;
      r_mtvec    <= '0;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
    end else if (i_ecall) begin
      r_mepc   <= {i_ecall_pc[DATA_WIDTH-1:2], 2'b00};
      r_mcause <= 32'd11;
      r_mpie   <= r_mie;
      r_mie    <= 1'b0;
    end else if (i_mret) begin
      r_mie  <= r_mpie;
      r_mpie <= 1'b1;
    end else if (w_wen) begin
      case (i_csr_addr)
        A_MSTATUS: begin
          r_mie  <= i_csr_wdata[3];
          r_mpie <= i_csr_wdata[7];
        end
        A_MTVEC:    r_mtvec    <= {i_csr_wdata[DATA_WIDTH-1:2], 2'b00};
        A_MSCRATCH: r_mscratch <= i_csr_wdata;
        A_MEPC:     r_mepc     <= {i_csr_wdata[DATA_WIDTH-1:2], 2'b00};
        A_MCAUSE:   r_mcause   <= i_csr_wdata;
        default: ;
      endcase
    end
  end

  // A half-word write lands unincremented; a high-word write drops the low-word carry
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mcycle  <= '0;
      r_mcycleh <= '0;
    end else if (w_wen && i_csr_addr == A_MCYCLE) begin
      r_mcycle <= i_csr_wdata;
    end else if (w_wen && i_csr_addr == A_MCYCLEH) begin
      r_mcycleh <= i_csr_wdata;
      r_mcycle  <= w_cyc_inc[31:0];
    end else begin
      r_mcycleh <= w_cyc_inc[63:32];
      r_mcycle  <= w_cyc_inc[31:0];
    end
  end

endmodule

// File: tb/tb_ysyx_24100012_csr_regfile.sv
// Bench for the CSR file: a behavioural CSR model checked every cycle, plus
// literal expectations for reset, masking, traps, counter wrap and async reset.
module tb_ysyx_24100012_csr_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] addr;
  logic        wen;
  logic [31:0] wdata;
  logic        ecall;
  logic [31:0] epc;
  logic        mret;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] mtvec;
  logic [31:0] mepc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_24100012_csr_regfile dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_csr_addr(addr), .i_csr_wen(wen), .i_csr_wdata(wdata), .o_csr_rdata(rdata),
    .o_csr_err(err), .i_ecall(ecall), .i_ecall_pc(epc), .i_mret(mret),
    .o_mtvec(mtvec), .o_mepc(mepc)
  );

  // ---------------- behavioural model ----------------
  logic        m_mie, m_mpie;
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
  logic [63:0] m_cyc;

  task automatic m_reset();
    m_mie = 0; m_mpie = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_cyc = 0;
  endtask

  function automatic bit m_impl(input logic [11:0] a);
    return a inside {12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'hB80, 12'hF11, 12'hF12};
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 + (32'(m_mie) * 8) + (32'(m_mpie) * 128);
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'hB00: return m_cyc[31:0];
      12'hB80: return m_cyc[63:32];
      12'hF11: return 32'h7973_7978;
      12'hF12: return 32'h016F_3A1C;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic [63:0] nxt;
    if (!rst_n) m_reset();
    else begin
      nxt = m_cyc + 64'd1;
      if (ecall) begin
        m_mepc = epc & ~32'h3; m_mcause = 32'd11; m_mpie = m_mie; m_mie = 0;
      end else if (mret) begin
        m_mie = m_mpie; m_mpie = 1;
      end else if (wen) begin
        case (addr)
          12'h300: begin m_mie = wdata[3]; m_mpie = wdata[7]; end
          12'h305: m_mtvec = wdata & ~32'h3;
          12'h340: m_mscratch = wdata;
          12'h341: m_mepc = wdata & ~32'h3;
          12'h342: m_mcause = wdata;
          12'hB00: nxt = {m_cyc[63:32], wdata};
          12'hB80: nxt = {wdata, nxt[31:0]};
          default: ;
        endcase
      end
      m_cyc = nxt;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model rdata", rdata, m_read(addr));
    chk("model err", {31'd0, err},
        {31'd0, !m_impl(addr) || (wen && !ecall && !mret && (addr == 12'hF11 || addr == 12'hF12))});
    chk("model mtvec_o", mtvec, m_mtvec);
    chk("model mepc_o", mepc, m_mepc);
  end

  // ---------------- directed stimulus ----------------
  task automatic apply(input logic [11:0] a, input logic w, input logic [31:0] d,
                       input logic e, input logic [31:0] pc, input logic m);
    @(posedge clk); #1;
    addr = a; wen = w; wdata = d; ecall = e; epc = pc; mret = m;
    @(negedge clk); #1;
  endtask

  task automatic rd(input logic [11:0] a);
    apply(a, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    apply(a, 1'b1, d, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    m_reset();
    rst_n = 0; addr = 12'h300; wen = 0; wdata = 0; ecall = 0; epc = 0; mret = 0;
    @(negedge clk); #1;
    chk("reset mstatus", rdata, 32'h0000_1800);
    @(posedge clk); #1;
    rst_n = 1; addr = 12'hB00;
    @(negedge clk); #1;
    chk("mcycle first cycle", rdata, 32'd0);
    rd(12'hB00);  chk("mcycle second cycle", rdata, 32'd1);
    rd(12'h305);  chk("reset mtvec", rdata, 32'd0);
    rd(12'h342);  chk("reset mcause", rdata, 32'd0);

    wr(12'h305, 32'h8000_0103); chk("mtvec same-cycle old", rdata, 32'd0);
    rd(12'h305);  chk("mtvec masked", rdata, 32'h8000_0100);
    chk("mtvec_o", mtvec, 32'h8000_0100);
    wr(12'h300, 32'hFFFF_FFFF); chk("mstatus same-cycle old", rdata, 32'h1800);
    rd(12'h300);  chk("mstatus masked", rdata, 32'h0000_1888);

    apply(12'h341, 1'b1, 32'h1234_5678, 1'b1, 32'h8000_0010, 1'b0);
    chk("ecall err", {31'd0, err}, 32'd0);
    rd(12'h341);  chk("ecall mepc", rdata, 32'h8000_0010);
    rd(12'h342);  chk("ecall mcause", rdata, 32'd11);
    rd(12'h300);  chk("ecall mstatus", rdata, 32'h1880);
    apply(12'h300, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1);
    chk("mret mepc_o", mepc, 32'h8000_0010);
    rd(12'h300);  chk("mret mstatus", rdata, 32'h1888);

    wr(12'hB80, 32'hFFFF_FFFF);
    wr(12'hB00, 32'hFFFF_FFFE);
    rd(12'hB00);  chk("mcycle written", rdata, 32'hFFFF_FFFE);
    rd(12'hB80);  chk("mcycleh all ones", rdata, 32'hFFFF_FFFF);
    rd(12'hB00);  chk("mcycle wrapped", rdata, 32'd0);
    addr = 12'hB80; #1;
    chk("mcycleh wrapped", rdata, 32'd0);

    rd(12'h7C0);  chk("unimpl rdata", rdata, 32'd0);
    chk("unimpl err", {31'd0, err}, 32'd1);
    wr(12'hF11, 32'h0); chk("ro write err", {31'd0, err}, 32'd1);
    rd(12'hF11);  chk("mvendorid", rdata, 32'h7973_7978);
    chk("ro read err", {31'd0, err}, 32'd0);
    rd(12'hF12);  chk("marchid", rdata, 32'h016F_3A1C);
    wr(12'h340, 32'hA5A5_A5A5);
    rd(12'h340);  chk("mscratch", rdata, 32'hA5A5_A5A5);
    wr(12'h341, 32'h0000_1237);
    rd(12'h341);  chk("mepc masked", rdata, 32'h0000_1234);
    wr(12'h342, 32'hFFFF_FFFF);
    rd(12'h342);  chk("mcause full", rdata, 32'hFFFF_FFFF);

    wr(12'h341, 32'hDEAD_BEEC);
    rst_n = 0; #1;
    chk("async rst mepc", rdata, 32'd0);
    chk("async rst mtvec_o", mtvec, 32'd0);
    addr = 12'h300; #1;
    chk("async rst mstatus", rdata, 32'h1800);
    addr = 12'hB00; #1;
    chk("async rst mcycle", rdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1; addr = 12'h341; wen = 0;
    @(negedge clk); #1;
    chk("write dropped by reset", rdata, 32'd0);

    wr(12'h300, 32'h0000_0008);
    apply(12'h341, 1'b1, 32'h5555_5555, 1'b1, 32'h0000_0043, 1'b1);
    rd(12'h341);  chk("ecall+mret mepc", rdata, 32'h0000_0040);
    rd(12'h300);  chk("ecall+mret mstatus", rdata, 32'h1880);

    rd(12'h300);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
